sys_rst_ctrl: RTL and testbench
===============================

// Module: sys_rst_ctrl
// PURPOSE
//  Reset sequencer sitting directly downstream of the system PLL. Waits for
//  the PLL lock, synchronises it into the PLL output clock domain and holds
//  the system reset for a fixed stabilisation delay. Also provides a
//  debug-requested system reset that leaves the debug domain running.
//  Drives the active-low resets of the CPU/SoC and debug module domains.
// PARAMETERS
//  SYNC_STAGES   2     flops in the i_pll_locked synchroniser (>=2)
//  DELAY_CYCLES  1024  i_clk cycles held in reset after lock (>=1)
//  DMRST_CYCLES  16    length in cycles of a debug-requested sys reset (>=1)
// PORTS
//  i_clk         in   1  system clock (PLL output clock)
//  i_rst         in   1  external reset, asynchronous, active-high
//  i_pll_locked  in   1  PLL lock, asynchronous to i_clk
//  i_dmreset     in   1  debug-module sys-reset request, sync to i_clk, level
//  o_locked      out  1  synchronised lock status
//  o_sys_nrst    out  1  SoC/CPU reset, active-low, registered
//  o_dbg_nrst    out  1  debug-domain reset, active-low, registered
//  o_state       out  2  current state (0 WAIT, 1 CNT, 2 RUN, 3 DMRST)
// BEHAVIOUR
//  - Clock and reset: single clock i_clk. i_rst is asynchronous, active-high.
//  - Reset (i_rst=1), applied asynchronously:
//      sync chain=0, o_locked=0, state=WAIT, cnt=0, o_sys_nrst=0, o_dbg_nrst=0.
//  - Synchroniser: i_pll_locked passes through SYNC_STAGES flops.
//      o_locked equals the last flop.
//  - Counter: cnt width is $clog2(max(DELAY_CYCLES, DMRST_CYCLES)+1).
//      cnt never wraps; it saturates at its terminal value.
//  - Output timing: outputs are dedicated flops, written on the same edge as
//      state. They are never decoded combinationally, so they are glitch-free.
//  - FSM transitions, evaluated in priority order each edge:
//    WAIT : o_locked=1 -> CNT, cnt<=0. Outputs stay 0.
//    CNT  : o_locked=0 -> WAIT.
//           cnt==DELAY_CYCLES-1 -> RUN, o_sys_nrst<=1, o_dbg_nrst<=1.
//           else cnt++.
//    RUN  : o_locked=0 -> WAIT, both outputs<=0.
//           i_dmreset=1 -> DMRST, cnt<=0, o_sys_nrst<=0, o_dbg_nrst stays 1.
//    DMRST: o_locked=0 -> WAIT, both outputs<=0.
//           i_dmreset=1 -> cnt<=0 (reload; reset extends while held).
//           cnt==DMRST_CYCLES-1 -> RUN, o_sys_nrst<=1.
//           else cnt++.
//  - Lock-loss priority: lock loss overrides i_dmreset in every state.
//  - i_dmreset outside RUN/DMRST is ignored.
//  - Release latency: o_locked rises SYNC_STAGES edges after i_pll_locked is
//      first sampled high. o_sys_nrst rises DELAY_CYCLES+1 edges after that.
//  - Lock-loss latency: both outputs fall SYNC_STAGES+1 edges after
//      i_pll_locked is first sampled low.
//  - i_rst asserted mid-operation forces outputs low immediately, with no
//      clock required. After release the full sequence restarts from WAIT.
//  - A lock glitch shorter than one cycle may be missed; that is acceptable.
//      A glitch seen by the synchroniser restarts the delay.
// TESTING  (SYNC_STAGES=2, DELAY_CYCLES=8, DMRST_CYCLES=4)
//  1 Power-up: i_rst=1 for 3 clks, release, i_pll_locked=1 from edge 0.
//      -> o_locked=1 at edge 2, o_sys_nrst=o_dbg_nrst=1 at edge 11.
//      -> Both outputs are 0 at every earlier edge.
//  2 Lock lost mid-count: drop i_pll_locked for 3 clks at edge 6, then restore.
//      -> FSM returns to WAIT.
//      -> o_sys_nrst rises 11 edges after the lock is restored.
//  3 Lock lost in RUN: drop i_pll_locked.
//      -> Both outputs fall exactly 3 edges later.
//      -> Outputs recover per scenario 1 once the lock returns.
//  4 Debug reset: in RUN, pulse i_dmreset for 1 clk.
//      -> o_sys_nrst=0 for exactly 4 clks, o_dbg_nrst stays 1.
//      -> Repeat with i_dmreset held 10 clks: o_sys_nrst=0 for 13 clks.
//  5 Async reset mid-CNT: assert i_rst between clock edges.
//      -> Outputs and o_locked go 0 before the next edge.
//      -> After release, the sequence runs as in scenario 1.
//  6 Simultaneous events: in RUN, drop the lock and raise i_dmreset together.
//      -> FSM ends in WAIT, o_dbg_nrst falls.
//      -> i_dmreset in WAIT/CNT causes no state change.

Source files
------------

// File: rtl/sys_rst_ctrl.sv
// Reset sequencer downstream of the system PLL: synchronises the PLL lock, holds the
// SoC in reset for a stabilisation delay, and supports debug-requested SoC resets.
module sys_rst_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int DELAY_CYCLES = 1024,
    parameter int DMRST_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    input  logic       i_dmreset,
    output logic       o_locked,
    output logic       o_sys_nrst,
    output logic       o_dbg_nrst,
    output logic [1:0] o_state
);

    localparam int MAX_CYCLES = (DELAY_CYCLES > DMRST_CYCLES) ? DELAY_CYCLES : DMRST_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] DMRST_LAST = CNT_W'(DMRST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CNT   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DMRST = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;

    // Lock is asynchronous to i_clk; the last flop of this chain is the only consumer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pll_locked};
        end
    end

    assign o_locked = sync_q[SYNC_STAGES-1];
    assign o_state  = state;

    // Counter only advances up to the terminal compare, so it can never wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_WAIT;
            cnt        <= '0;
            o_sys_nrst <= 1'b0;
            o_dbg_nrst <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    o_sys_nrst <= 1'b0;
                    o_dbg_nrst <= 1'b0;
                    if (o_locked) begin
                        state <= ST_CNT;
                        cnt   <= '0;
                    end
                end
                ST_CNT: begin
                    if (!o_locked) begin
                        state <= ST_WAIT;
                    end else if (cnt == DELAY_LAST) begin
                        state      <= ST_RUN;
                        o_sys_nrst <= 1'b1;
                        o_dbg_nrst <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!o_locked) begin
                        state      <= ST_WAIT;
                        o_sys_nrst <= 1'b0;
                        o_dbg_nrst <= 1'b0;
                    end else if (i_dmreset) begin
                        state      <= ST_DMRST;
                        cnt        <= '0;
                        o_sys_nrst <= 1'b0;
                    end
                end
                ST_DMRST: begin
                    // A held request keeps reloading, stretching the SoC reset.
                    if (!o_locked) begin
                        state      <= ST_WAIT;
                        o_sys_nrst <= 1'b0;
                        o_dbg_nrst <= 1'b0;
                    end else if (i_dmreset) begin
                        cnt <= '0;
                    end else if (cnt == DMRST_LAST) begin
                        state      <= ST_RUN;
                        o_sys_nrst <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= ST_WAIT;
                    o_sys_nrst <= 1'b0;
                    o_dbg_nrst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_rst_ctrl.sv
// Directed bench for sys_rst_ctrl with SYNC_STAGES=2, DELAY_CYCLES=8, DMRST_CYCLES=4.
module tb_sys_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       dmreset = 1'b0;
    logic       locked;
    logic       sys_nrst;
    logic       dbg_nrst;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    sys_rst_ctrl #(
        .SYNC_STAGES (2),
        .DELAY_CYCLES(8),
        .DMRST_CYCLES(4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pll_locked(pll_locked),
        .i_dmreset   (dmreset),
        .o_locked    (locked),
        .o_sys_nrst  (sys_nrst),
        .o_dbg_nrst  (dbg_nrst),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic p, input logic d);
        rst        = r;
        pll_locked = p;
        dmreset    = d;
    endtask

    // Advance n rising edges, leaving time just past the last one for sampling.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Lock is high and reset has just been released; edge 1 is the first sampling edge.
    task automatic powerUp(input string tag);
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            checkOutput($sformatf("%s_locked_e%0d", tag, e), locked, (e >= 2));
            checkOutput($sformatf("%s_sys_e%0d", tag, e), sys_nrst, (e >= 11));
            checkOutput($sformatf("%s_dbg_e%0d", tag, e), dbg_nrst, (e >= 11));
        end
        checkOutput($sformatf("%s_state_run", tag), state, 2);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_sys", sys_nrst, 0);
        checkOutput("rst_dbg", dbg_nrst, 0);
        checkOutput("rst_state", state, 0);

        // Power-up with lock already present
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(2);
        rst = 1'b0;
        powerUp("s1");

        // Lock lost mid-count, restored after three cycles
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);
        checkOutput("s2_state_cnt_e6", state, 1);
        pll_locked = 1'b0;
        tick(2);
        checkOutput("s2_state_cnt_e8", state, 1);
        tick(1);
        checkOutput("s2_state_wait_e9", state, 0);
        checkOutput("s2_sys_wait_e9", sys_nrst, 0);
        pll_locked = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick(1);
            checkOutput($sformatf("s2_sys_r%0d", e), sys_nrst, (e >= 11));
        end

        // Lock lost in RUN, then recovery
        pll_locked = 1'b0;
        tick(1);
        checkOutput("s3_sys_e1", sys_nrst, 1);
        tick(1);
        checkOutput("s3_sys_e2", sys_nrst, 1);
        checkOutput("s3_dbg_e2", dbg_nrst, 1);
        tick(1);
        checkOutput("s3_sys_e3", sys_nrst, 0);
        checkOutput("s3_dbg_e3", dbg_nrst, 0);
        checkOutput("s3_state_e3", state, 0);
        pll_locked = 1'b1;
        powerUp("s3rec");

        // Debug reset: single-cycle pulse
        dmreset = 1'b1;
        tick(1);
        dmreset = 1'b0;
        checkOutput("s4p_sys_e1", sys_nrst, 0);
        checkOutput("s4p_dbg_e1", dbg_nrst, 1);
        checkOutput("s4p_state_e1", state, 3);
        for (int e = 2; e <= 5; e++) begin
            tick(1);
            checkOutput($sformatf("s4p_sys_e%0d", e), sys_nrst, (e >= 5));
            checkOutput($sformatf("s4p_dbg_e%0d", e), dbg_nrst, 1);
        end

        // Debug reset held for ten cycles
        dmreset = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick(1);
            if (e == 10) dmreset = 1'b0;
            checkOutput($sformatf("s4h_sys_e%0d", e), sys_nrst, (e >= 14));
            checkOutput($sformatf("s4h_dbg_e%0d", e), dbg_nrst, 1);
        end

        // Async reset in RUN and mid-CNT, no clock edge needed
        #3;
        rst = 1'b1;
        #1;
        checkOutput("s5run_sys", sys_nrst, 0);
        checkOutput("s5run_dbg", dbg_nrst, 0);
        checkOutput("s5run_locked", locked, 0);
        checkOutput("s5run_state", state, 0);
        tick(1);
        rst = 1'b0;
        tick(5);
        checkOutput("s5_state_cnt", state, 1);
        checkOutput("s5_locked_cnt", locked, 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("s5cnt_locked", locked, 0);
        checkOutput("s5cnt_state", state, 0);
        checkOutput("s5cnt_sys", sys_nrst, 0);
        tick(2);
        rst = 1'b0;
        powerUp("s5");

        // Lock loss and debug request together: lock loss wins
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("s6_state_e1", state, 3);
        checkOutput("s6_dbg_e1", dbg_nrst, 1);
        tick(2);
        checkOutput("s6_state_e3", state, 0);
        checkOutput("s6_dbg_e3", dbg_nrst, 0);
        checkOutput("s6_sys_e3", sys_nrst, 0);
        tick(3);
        checkOutput("s6_state_wait_hold", state, 0);
        pll_locked = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick(1);
            if (e == 10) dmreset = 1'b0;
            checkOutput($sformatf("s6_state_r%0d", e), state, (e < 3) ? 0 : ((e < 11) ? 1 : 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
